// File: rtl/cmp_vote_pkg.sv
// Shared types and defaults for the comparator majority-vote stage.
// The CNT_WIDTH and SETTLE_CYCLES defaults are also used by the threshold
// search controller, so both blocks agree on counter and settle sizing.
package cmp_vote_pkg;

    localparam int CMP_VOTE_CNT_WIDTH     = 8;
    localparam int CMP_VOTE_SETTLE_CYCLES = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } cmp_vote_state_t;

endpackage

// File: rtl/cmp_sync.sv
// Multi-stage asynchronous-reset synchronizer for the raw comparator bit.
module cmp_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain; reset clears every stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cmp_vote.sv
// Comparator sampling and majority-vote stage.
// Requests a strobe, waits for stb_valid_i, lets the synchronized comparator
// settle, samples it, and repeats n_samples_i times before reporting a
// majority decision and the raw hit count.
// Optional feature: define CMP_VOTE_TIMEOUT_EN to build the strobe-wait
// watchdog; otherwise timeout_o is held at 0 and REQ waits indefinitely.
module cmp_vote
    import cmp_vote_pkg::*;
#(
    parameter int          SYNC_STAGES    = 2,
    parameter int          CNT_WIDTH      = CMP_VOTE_CNT_WIDTH,
    parameter int          SETTLE_CYCLES  = CMP_VOTE_SETTLE_CYCLES,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 cmp_i,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] n_samples_i,
    output logic                 stb_req_o,
    input  logic                 stb_valid_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 result_o,
    output logic [CNT_WIDTH-1:0] ones_cnt_o,
    output logic                 timeout_o
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    cmp_vote_state_t      state, state_nxt;
    logic [CNT_WIDTH-1:0] n_reg;
    logic [CNT_WIDTH-1:0] samples, samples_nxt;
    logic [CNT_WIDTH-1:0] ones, ones_nxt;
    logic [CNT_WIDTH-1:0] n_cur;
    logic [SW-1:0]        settle_cnt;
    logic                 sync_bit;
    logic                 wdog_expired;
    logic                 timed_out;

    // Strict majority at CNT_WIDTH+1 bits; a tie reports 0.
    function automatic logic majority(input logic [CNT_WIDTH-1:0] hits,
                                      input logic [CNT_WIDTH-1:0] total);
        return ({hits, 1'b0} > {1'b0, total});
    endfunction

    cmp_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(wb_clk_i),
        .rst(wb_rst_i),
        .d  (cmp_i),
        .q  (sync_bit)
    );

`ifdef CMP_VOTE_TIMEOUT_EN
    logic [31:0] wdog;

    // Count consecutive cycles spent waiting in REQ; any strobe or exit restarts it.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wdog <= 32'd0;
        end else if ((state == REQ) && !stb_valid_i) begin
            wdog <= wdog + 32'd1;
        end else begin
            wdog <= 32'd0;
        end
    end

    assign wdog_expired = (state == REQ) && (wdog >= (TIMEOUT_CYCLES - 32'd1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign wdog_expired       = 1'b0;
`endif

    // Next-state and next-counter decode for the vote sequence.
    always_comb begin
        state_nxt   = state;
        ones_nxt    = ones;
        samples_nxt = samples;
        n_cur       = n_reg;
        timed_out   = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    n_cur       = n_samples_i;
                    ones_nxt    = '0;
                    samples_nxt = '0;
                    state_nxt   = (n_samples_i == '0) ? DONE : REQ;
                end else begin
                    state_nxt = IDLE;
                end
            end
            REQ: begin
                if (stb_valid_i) begin
                    state_nxt = SETTLE;
                end else if (wdog_expired) begin
                    timed_out = 1'b1;
                    state_nxt = DONE;
                end else begin
                    state_nxt = REQ;
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    state_nxt = SAMPLE;
                end else begin
                    state_nxt = SETTLE;
                end
            end
            SAMPLE: begin
                ones_nxt    = ones + {{(CNT_WIDTH-1){1'b0}}, sync_bit};
                samples_nxt = samples + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                if (samples_nxt == n_reg) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = REQ;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; outputs are decoded from the next state
    // so they line up with the state they describe.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            n_reg      <= '0;
            samples    <= '0;
            ones       <= '0;
            settle_cnt <= '0;
            stb_req_o  <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            result_o   <= 1'b0;
            ones_cnt_o <= '0;
            timeout_o  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ones    <= ones_nxt;
            samples <= samples_nxt;

            if ((state == IDLE) && start_i) begin
                n_reg <= n_samples_i;
            end else begin
                n_reg <= n_reg;
            end

            if ((state == REQ) && stb_valid_i) begin
                settle_cnt <= SW'(SETTLE_CYCLES - 1);
            end else if ((state == SETTLE) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - {{(SW-1){1'b0}}, 1'b1};
            end else begin
                settle_cnt <= settle_cnt;
            end

            stb_req_o <= (state_nxt == REQ);
            busy_o    <= (state_nxt == REQ) || (state_nxt == SETTLE) || (state_nxt == SAMPLE);
            done_o    <= (state_nxt == DONE);

            // Results are captured on entry to DONE and held until the next accepted start.
            if ((state_nxt == DONE) && (state != DONE)) begin
                result_o   <= majority(ones_nxt, n_cur);
                ones_cnt_o <= ones_nxt;
                timeout_o  <= timed_out;
            end else if ((state == IDLE) && start_i) begin
                result_o   <= 1'b0;
                ones_cnt_o <= '0;
                timeout_o  <= 1'b0;
            end else begin
                result_o   <= result_o;
                ones_cnt_o <= ones_cnt_o;
                timeout_o  <= timeout_o;
            end
        end
    end

endmodule
